// File: rtl/shift_reg_load_arbiter_if.sv
// Handshake and shift-register pin bundle between two byte producers, the
// round-robin load arbiter and the shared serial-in shift register.
interface shift_reg_load_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ready;
  logic             abort;
  logic             sr_en;
  logic             sr_serial_in;
  logic             busy;
  logic             done;
  logic             done_id;
  logic             aborted;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, abort,
    input  req0_ready, req1_ready, sr_en, sr_serial_in, busy, done, done_id, aborted
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, abort,
    output req0_ready, req1_ready, sr_en, sr_serial_in, busy, done, done_id, aborted
  );
endinterface

// File: rtl/shift_reg_load_arbiter.sv
// Round-robin arbiter that serially loads a granted byte, MSB first, into a
// shared shift-left register, holds it for HOLD_CYCLES, then reports done.
module shift_reg_load_arbiter #(
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  shift_reg_load_arbiter_if.slave  bus
);
  localparam int CNT_W  = $clog2(WIDTH) + 1;
  localparam int HOLD_W = 4;

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shadow_q, shadow_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               owner_q, owner_d;
  logic               last_grant_q, last_grant_d;
  logic               sr_en_q, sr_en_d;
  logic               ser_q, ser_d;
  logic               done_q, done_d;
  logic               done_id_q, done_id_d;
  logic               aborted_q, aborted_d;
  logic               grant0, grant1;

  // Ready is masked by rst so it drops the instant reset asserts.
  assign grant0 = (state_q == IDLE) && !rst && bus.req0_valid &&
                  (!bus.req1_valid || last_grant_q);
  assign grant1 = (state_q == IDLE) && !rst && bus.req1_valid &&
                  (!bus.req0_valid || !last_grant_q);

  assign bus.req0_ready   = grant0;
  assign bus.req1_ready   = grant1;
  assign bus.sr_en        = sr_en_q;
  assign bus.sr_serial_in = ser_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.done         = done_q;
  assign bus.done_id      = done_id_q;
  assign bus.aborted      = aborted_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      shadow_q     <= '0;
      cnt_q        <= '0;
      hold_q       <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      sr_en_q      <= 1'b0;
      ser_q        <= 1'b0;
      done_q       <= 1'b0;
      done_id_q    <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      sr_en_q      <= sr_en_d;
      ser_q        <= ser_d;
      done_q       <= done_d;
      done_id_q    <= done_id_d;
      aborted_q    <= aborted_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    cnt_d        = cnt_q;
    hold_d       = hold_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    sr_en_d      = 1'b0;
    ser_d        = 1'b0;
    done_d       = 1'b0;
    done_id_d    = 1'b0;
    aborted_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          shadow_d     = grant1 ? bus.req1_data : bus.req0_data;
          owner_d      = grant1;
          last_grant_d = grant1;
          cnt_d        = '0;
          sr_en_d      = 1'b1;
          ser_d        = shadow_d[WIDTH-1];
          state_d      = SHIFT;
        end
      end

      SHIFT: begin
        // Abort takes priority even on the last shift edge.
        if (bus.abort) begin
          aborted_d = 1'b1;
          state_d   = IDLE;
        end else if (cnt_q == CNT_W'(WIDTH - 1)) begin
          done_d    = 1'b1;
          done_id_d = owner_q;
          hold_d    = '0;
          state_d   = HOLD;
        end else begin
          shadow_d = {shadow_q[WIDTH-2:0], 1'b0};
          cnt_d    = cnt_q + CNT_W'(1);
          sr_en_d  = 1'b1;
          ser_d    = shadow_q[WIDTH-2];
        end
      end

      HOLD: begin
        if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_shift_reg_load_arbiter.sv
// Directed-vector bench: stimulus queues expected grants and completions,
// an independent monitor rebuilds the loaded byte from the serial pins.
module tb_shift_reg_load_arbiter;
  localparam int W = 8;
  localparam int H = 2;

  typedef struct {bit id; logic [7:0] data;} grant_t;
  typedef struct {bit is_abort; bit id; logic [7:0] data; int nshift;} res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  grant_t gq[$];
  res_t   rq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  shift_reg_load_arbiter_if #(.WIDTH(W)) bus ();

  shift_reg_load_arbiter #(.WIDTH(W), .HOLD_CYCLES(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  task automatic fail_timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: got timeout expected event at cycle %0d", name, cyc);
  endtask

  function automatic grant_t mk_g(input bit id, input logic [7:0] d);
    grant_t g;
    g.id = id; g.data = d;
    return g;
  endfunction

  function automatic res_t mk_r(input bit ab, input bit id, input logic [7:0] d, input int n);
    res_t r;
    r.is_abort = ab; r.id = id; r.data = d; r.nshift = n;
    return r;
  endfunction

  // Monitor: one line per observed transaction end.
  initial begin
    logic [7:0] msr;
    int nsh, since;
    bit prev_en, gid;
    logic [7:0] gdata;
    res_t e;
    grant_t g;
    msr = 0; nsh = 0; since = 0; prev_en = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        msr = 0; nsh = 0; since = 0; prev_en = 0;
        continue;
      end
      since++;
      if (bus.sr_en) begin
        msr = {msr[6:0], bus.sr_serial_in};
        nsh++;
        if (!prev_en) chk("shift_start_latency", since, 1);
      end
      prev_en = bus.sr_en;
      if (bus.done || bus.aborted) begin
        if (rq.size() == 0) begin
          chk("unexpected_event", {30'd0, bus.done, bus.aborted}, 0);
        end else begin
          e = rq.pop_front();
          chk("aborted_flag", bus.aborted, e.is_abort);
          chk("done_flag", bus.done, !e.is_abort);
          chk("shift_count", nsh, e.nshift);
          if (!e.is_abort) begin
            chk("done_id", bus.done_id, e.id);
            chk("loaded_byte", msr, e.data);
            chk("done_latency", since, W + 1);
            $display("done id=%0d byte=%02h shifts=%0d", bus.done_id, msr, nsh);
          end else begin
            chk("abort_sr_en", bus.sr_en, 0);
            chk("abort_busy", bus.busy, 0);
            $display("aborted after %0d shifts", nsh);
          end
        end
      end
      if ((bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready)) begin
        chk("ready_exclusive", bus.req0_ready & bus.req1_ready, 0);
        chk("ready_when_idle", bus.busy, 0);
        gid   = bus.req1_valid && bus.req1_ready;
        gdata = gid ? bus.req1_data : bus.req0_data;
        if (gq.size() == 0) begin
          chk("unexpected_grant", {31'd0, gid}, 32'hFFFF_FFFF);
        end else begin
          g = gq.pop_front();
          chk("grant_id", gid, g.id);
          chk("grant_data", gdata, g.data);
        end
        $display("accept id=%0d data=%02h cycle=%0d", gid, gdata, cyc);
        since = 0; msr = 0; nsh = 0;
      end
    end
  end

  task automatic wait_accept(output int at);
    at = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if ((bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready)) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) fail_timeout("accept_wait");
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!bus.busy) begin ok = 1; break; end
    end
    if (!ok) fail_timeout("idle_wait");
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    int at, prev;
    bus.req0_valid = 1'b1; bus.req0_data = 8'hA5;
    bus.req1_valid = 1'b0; bus.req1_data = 8'h00;
    bus.abort = 1'b0;

    // Reset state, with a valid pending that must not see ready.
    @(negedge clk);
    chk("rst_sr_en", bus.sr_en, 0);
    chk("rst_serial", bus.sr_serial_in, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_done_id", bus.done_id, 0);
    chk("rst_aborted", bus.aborted, 0);
    chk("rst_ready0", bus.req0_ready, 0);
    chk("rst_ready1", bus.req1_ready, 0);

    // Single load of A5 from requester 0.
    gq.push_back(mk_g(0, 8'hA5));
    rq.push_back(mk_r(0, 0, 8'hA5, W));
    @(posedge clk); #1 rst = 1'b0;
    #1 chk("t1_ready0_same_cycle", bus.req0_ready, 1);
    wait_accept(at);
    bus.req0_valid = 1'b0;
    wait_idle();

    // Both requesters held from reset: 0,1,0,1 with 11-cycle spacing.
    rst = 1'b1;
    @(posedge clk); #1;
    bus.req0_valid = 1'b1; bus.req0_data = 8'h3C;
    bus.req1_valid = 1'b1; bus.req1_data = 8'hC3;
    for (int k = 0; k < 4; k++) begin
      gq.push_back(mk_g(k[0], k[0] ? 8'hC3 : 8'h3C));
      rq.push_back(mk_r(0, k[0], k[0] ? 8'hC3 : 8'h3C, W));
    end
    rst = 1'b0;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_accept(at);
      if (k > 0) chk("t2_accept_gap", at - prev, W + H + 1);
      prev = at;
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    wait_idle();

    // Requester 1 alone twice in a row.
    bus.req1_valid = 1'b1; bus.req1_data = 8'hFF;
    repeat (2) begin
      gq.push_back(mk_g(1, 8'hFF));
      rq.push_back(mk_r(0, 1, 8'hFF, W));
    end
    wait_accept(prev);
    wait_accept(at);
    chk("t3_accept_gap", at - prev, W + H + 1);
    bus.req1_valid = 1'b0;
    wait_idle();

    // Abort on the 4th shift cycle, then a clean load of 0F.
    bus.req0_valid = 1'b1; bus.req0_data = 8'h81;
    gq.push_back(mk_g(0, 8'h81));
    rq.push_back(mk_r(1, 0, 8'h00, 4));
    wait_accept(at);
    bus.req0_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 bus.abort = 1'b1;
    @(posedge clk); #1 bus.abort = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_data = 8'h0F;
    gq.push_back(mk_g(0, 8'h0F));
    rq.push_back(mk_r(0, 0, 8'h0F, W));
    wait_accept(at);
    bus.req0_valid = 1'b0;
    wait_idle();

    // Abort coinciding with the final shift cycle: abort wins.
    bus.req0_valid = 1'b1; bus.req0_data = 8'h96;
    gq.push_back(mk_g(0, 8'h96));
    rq.push_back(mk_r(1, 0, 8'h00, W));
    wait_accept(at);
    bus.req0_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1 bus.abort = 1'b1;
    @(posedge clk); #1 bus.abort = 1'b0;
    wait_idle();

    // Abort held through HOLD is ignored.
    bus.req0_valid = 1'b1; bus.req0_data = 8'h5A;
    gq.push_back(mk_g(0, 8'h5A));
    rq.push_back(mk_r(0, 0, 8'h5A, W));
    wait_accept(at);
    bus.req0_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1 bus.abort = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus.abort = 1'b0;
    wait_idle();

    // Asynchronous reset mid-shift, then both valid: requester 0 first.
    bus.req0_valid = 1'b1; bus.req0_data = 8'h77;
    gq.push_back(mk_g(0, 8'h77));
    wait_accept(at);
    bus.req0_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("t6_rst_sr_en", bus.sr_en, 0);
    chk("t6_rst_busy", bus.busy, 0);
    bus.req0_valid = 1'b1; bus.req0_data = 8'h12;
    bus.req1_valid = 1'b1; bus.req1_data = 8'h34;
    #1;
    chk("t6_rst_ready0", bus.req0_ready, 0);
    chk("t6_rst_ready1", bus.req1_ready, 0);
    gq.push_back(mk_g(0, 8'h12));
    gq.push_back(mk_g(1, 8'h34));
    rq.push_back(mk_r(0, 0, 8'h12, W));
    rq.push_back(mk_r(0, 1, 8'h34, W));
    @(posedge clk); #1 rst = 1'b0;
    #1;
    chk("t6_post_rst_ready0", bus.req0_ready, 1);
    chk("t6_post_rst_ready1", bus.req1_ready, 0);
    wait_accept(at);
    wait_accept(at);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk);

    chk("grant_queue_empty", gq.size(), 0);
    chk("result_queue_empty", rq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
